// File: rtl/regfile_sb.sv
// Two-read/one-write register file for the pipelined core, with hardwired x0, optional write bypass,
// a busy-bit scoreboard for hazard stalls and a post-reset sweep that loads every register.
module regfile_sb #(
   parameter int               XLEN       = 32,
   parameter int               NREGS      = 32,
   parameter int               BYPASS     = 1,
   parameter int               PRESET_IDX = 9,
   parameter logic [XLEN-1:0]  PRESET_VAL = 32'h00000020,
   localparam int              AW         = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   input  logic            use1,
   input  logic            use2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic            iss,
   input  logic [AW-1:0]   iss_rd,
   output logic            busy1,
   output logic            busy2,
   output logic            stall,
   output logic            ready
);

   localparam logic [AW-1:0] LAST     = AW'(NREGS - 1);
   localparam logic [AW-1:0] PRESET_A = AW'(PRESET_IDX);

   typedef enum logic [0:0] {SWEEP, RUN} state_t;

   state_t          state;
   logic [AW-1:0]   cnt;
   logic [NREGS-1:0] busy;
   logic [XLEN-1:0] mem [NREGS];
   logic [XLEN-1:0] sweep_val;
   logic            wr_en;
   logic            fwd1;
   logic            fwd2;

   assign wr_en     = we && (wa != '0);
   assign sweep_val = ((PRESET_IDX != 0) && (cnt == PRESET_A)) ? PRESET_VAL : '0;
   assign fwd1      = (BYPASS != 0) && we && (wa == ra1);
   assign fwd2      = (BYPASS != 0) && we && (wa == ra2);

   // Busy bits only ever get set for nonzero destinations, so busy[0] stays 0;
   // the set is issued after the clear so a new producer wins on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SWEEP;
         cnt   <= '0;
         ready <= 1'b0;
         busy  <= '0;
      end else begin
         case (state)
            SWEEP: begin
               cnt <= cnt + AW'(1);
               if (cnt == LAST) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               if (wr_en) begin
                  busy[wa] <= 1'b0;
               end
               if (iss && (iss_rd != '0)) begin
                  busy[iss_rd] <= 1'b1;
               end
            end
            default: state <= SWEEP;
         endcase
      end
   end

   // Storage is not reset; the sweep defines every entry before reads are enabled.
   always_ff @(posedge clk) begin
      if (state == SWEEP) begin
         mem[cnt] <= sweep_val;
      end else if (wr_en) begin
         mem[wa] <= wd;
      end
   end

   always_comb begin
      rd1   = '0;
      rd2   = '0;
      busy1 = 1'b0;
      busy2 = 1'b0;
      if (state == RUN) begin
         if (ra1 != '0) begin
            rd1   = fwd1 ? wd : mem[ra1];
            busy1 = busy[ra1] && !fwd1;
         end
         if (ra2 != '0) begin
            rd2   = fwd2 ? wd : mem[ra2];
            busy2 = busy[ra2] && !fwd2;
         end
      end
   end

   assign stall = !ready || (use1 && busy1) || (use2 && busy2);

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: bypassing and non-bypassing instances share stimulus and are
// compared against an array-based reference model through an expectation queue.
module tb_regfile_sb;

   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int PIDX  = 9;
   localparam logic [31:0] PVAL = 32'h00000020;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] ra1 = '0, ra2 = '0, wa = '0, iss_rd = '0;
   logic          use1 = 1'b0, use2 = 1'b0, we = 1'b0, iss = 1'b0;
   logic [31:0]   wd = '0;

   logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic        busy1_a, busy2_a, busy1_b, busy2_b;
   logic        stall_a, stall_b, ready_a, ready_b;

   regfile_sb #(.BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
      .rd1(rd1_a), .rd2(rd2_a), .we(we), .wa(wa), .wd(wd), .iss(iss), .iss_rd(iss_rd),
      .busy1(busy1_a), .busy2(busy2_a), .stall(stall_a), .ready(ready_a)
   );

   regfile_sb #(.BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
      .rd1(rd1_b), .rd2(rd2_b), .we(we), .wa(wa), .wd(wd), .iss(iss), .iss_rd(iss_rd),
      .busy1(busy1_b), .busy2(busy2_b), .stall(stall_b), .ready(ready_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
      logic        busy1_a, busy2_a, busy1_b, busy2_b;
      logic        stall_a, stall_b, ready;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: register contents, busy flags and edges seen since reset.
   logic [31:0] m_mem  [NREGS];
   bit          m_busy [NREGS];
   int          m_edges = 0;
   bit          m_ready = 1'b0;

   function automatic logic [31:0] m_rd(input logic [AW-1:0] ra, input bit byp);
      if (rst || !m_ready || ra == 0) return 32'h0;
      if (byp && we && wa == ra) return wd;
      return m_mem[ra];
   endfunction

   function automatic bit m_bz(input logic [AW-1:0] ra, input bit byp);
      if (rst || !m_ready) return 1'b0;
      if (byp && we && wa == ra) return 1'b0;
      return m_busy[ra];
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Pushes the expected response for the current inputs, then advances the model over one edge.
   task automatic apply_stimulus(input string name);
      exp_t e;
      e.name    = name;
      e.rd1_a   = m_rd(ra1, 1'b1);
      e.rd2_a   = m_rd(ra2, 1'b1);
      e.rd1_b   = m_rd(ra1, 1'b0);
      e.rd2_b   = m_rd(ra2, 1'b0);
      e.busy1_a = m_bz(ra1, 1'b1);
      e.busy2_a = m_bz(ra2, 1'b1);
      e.busy1_b = m_bz(ra1, 1'b0);
      e.busy2_b = m_bz(ra2, 1'b0);
      e.ready   = !rst && m_ready;
      e.stall_a = !e.ready || (use1 && e.busy1_a) || (use2 && e.busy2_a);
      e.stall_b = !e.ready || (use1 && e.busy1_b) || (use2 && e.busy2_b);
      exp_q.push_back(e);
      @(posedge clk);
      if (rst) begin
         m_edges = 0;
         m_ready = 1'b0;
         for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
      end else if (!m_ready) begin
         m_edges++;
         if (m_edges == NREGS) begin
            m_ready = 1'b1;
            for (int i = 0; i < NREGS; i++) m_mem[i] = 32'h0;
            m_mem[PIDX] = PVAL;
         end
      end else begin
         if (we && wa != 0) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
         end
         if (iss && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      end
      #1;
   endtask

   // Monitor: outputs are combinational, so each cycle's response is sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_output({e.name, ".ready_a"}, 32'(ready_a), 32'(e.ready));
         check_output({e.name, ".ready_b"}, 32'(ready_b), 32'(e.ready));
         check_output({e.name, ".rd1_a"}, rd1_a, e.rd1_a);
         check_output({e.name, ".rd2_a"}, rd2_a, e.rd2_a);
         check_output({e.name, ".rd1_b"}, rd1_b, e.rd1_b);
         check_output({e.name, ".rd2_b"}, rd2_b, e.rd2_b);
         check_output({e.name, ".busy1_a"}, 32'(busy1_a), 32'(e.busy1_a));
         check_output({e.name, ".busy2_a"}, 32'(busy2_a), 32'(e.busy2_a));
         check_output({e.name, ".busy1_b"}, 32'(busy1_b), 32'(e.busy1_b));
         check_output({e.name, ".busy2_b"}, 32'(busy2_b), 32'(e.busy2_b));
         check_output({e.name, ".stall_a"}, 32'(stall_a), 32'(e.stall_a));
         check_output({e.name, ".stall_b"}, 32'(stall_b), 32'(e.stall_b));
      end
   end

   task automatic idle_inputs();
      we = 1'b0; iss = 1'b0; use1 = 1'b0; use2 = 1'b0;
      wa = '0; wd = '0; iss_rd = '0;
   endtask

   initial begin
      for (int i = 0; i < NREGS; i++) begin
         m_mem[i]  = 32'h0;
         m_busy[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      apply_stimulus("reset");

      // Sweep with preset readback
      rst = 1'b0; ra1 = 5'd9; ra2 = 5'd5;
      repeat (31) apply_stimulus("sweep");
      check_output("sweep_ready_low_31", 32'(ready_a), 32'd0);
      apply_stimulus("sweep_last");
      check_output("sweep_ready_32", 32'(ready_a), 32'd1);
      check_output("sweep_preset_rd1", rd1_a, 32'h20);
      check_output("sweep_rd2_zero", rd2_a, 32'h0);
      apply_stimulus("post_sweep");

      // Reset restarted at edge 10, with writes and issues that must be ignored
      rst = 1'b1;
      apply_stimulus("rst2");
      rst = 1'b0;
      repeat (10) apply_stimulus("sweep2");
      rst = 1'b1;
      apply_stimulus("rst_mid");
      rst = 1'b0;
      we = 1'b1; wa = 5'd2; wd = 32'h55; iss = 1'b1; iss_rd = 5'd2;
      repeat (31) apply_stimulus("sweep3");
      check_output("restart_ready_low", 32'(ready_a), 32'd0);
      apply_stimulus("sweep3_last");
      idle_inputs();
      ra1 = 5'd2; ra2 = 5'd2; use1 = 1'b1; use2 = 1'b1;
      apply_stimulus("sweep_ignored");
      check_output("sweep_ignored_rd", rd1_a, 32'h0);

      // Write and bypass
      idle_inputs();
      we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF; ra1 = 5'd3; ra2 = 5'd0;
      apply_stimulus("bypass_wr");
      we = 1'b0;
      apply_stimulus("bypass_next");

      // Zero register
      we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; use1 = 1'b1;
      apply_stimulus("zero_wr");
      we = 1'b0; iss = 1'b1; iss_rd = 5'd0;
      apply_stimulus("zero_iss");
      iss = 1'b0;
      repeat (2) apply_stimulus("zero_after");

      // Scoreboard hazard
      idle_inputs();
      iss = 1'b1; iss_rd = 5'd7;
      apply_stimulus("haz_iss");
      iss = 1'b0; ra2 = 5'd7; use2 = 1'b1;
      apply_stimulus("haz_use");
      use2 = 1'b0;
      apply_stimulus("haz_nouse");
      use2 = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'd5;
      apply_stimulus("haz_wb");
      we = 1'b0;
      apply_stimulus("haz_done");

      // Simultaneous set and clear
      idle_inputs();
      iss = 1'b1; iss_rd = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h1234;
      apply_stimulus("sc_edge");
      idle_inputs();
      ra1 = 5'd4; use1 = 1'b1;
      apply_stimulus("sc_busy");
      we = 1'b1; wa = 5'd4; wd = 32'hA5A5A5A5;
      apply_stimulus("sc_wb");
      we = 1'b0;
      apply_stimulus("sc_clear");

      // Randomized traffic with a narrow register window to provoke hazards
      for (int n = 0; n < 600; n++) begin
         rst    = ($urandom_range(0, 299) == 0);
         ra1    = AW'($urandom_range(0, 7));
         ra2    = AW'($urandom_range(0, 7));
         wa     = AW'($urandom_range(0, 7));
         iss_rd = AW'($urandom_range(0, 7));
         use1   = 1'($urandom);
         use2   = 1'($urandom);
         we     = ($urandom_range(0, 2) == 0);
         iss    = ($urandom_range(0, 2) == 0);
         wd     = $urandom;
         apply_stimulus("random");
      end
      rst = 1'b0;
      idle_inputs();

      for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain actual=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the single-cycle core's register file for the pipelined core. It provides a 2-read/1-write register array with a hardwired zero register and optional write-to-read bypass. It also holds a per-register busy scoreboard for hazard stalls. After reset, a post-reset sweep loads defined values into every register, including one preset register (stack/base pointer).

## Interface
- XLEN, 32, data width in bits.
- NREGS, 32, register count; power of two, ≥4. Address width AW = log2(NREGS), derived locally.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads see only stored contents.
- PRESET_IDX, 9, register loaded with PRESET_VAL during the sweep. 0 disables the preset.
- PRESET_VAL, 32'h00000020, preset value.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ra1, ra2  in  AW  read addresses.
- use1, use2  in  1  the decoded instruction actually consumes the ra1 / ra2 source.
- rd1, rd2  out  XLEN  read data, combinational.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- wd  in  XLEN  writeback data.
- iss  in  1  instruction issues with a destination register this cycle.
- iss_rd  in  AW  destination register of the issuing instruction.
- busy1, busy2  out  1  the source at ra1 / ra2 has a pending write that has not yet been written back.
- stall  out  1  the issue stage must hold.
- ready  out  1  the reset sweep is complete and the block is operational.

## Operation
- State machine: SWEEP → RUN.
  - Asynchronous rst forces SWEEP, sweep counter cnt=0, ready=0 and all busy bits =0.
  - rst asserted mid-sweep or in RUN restarts from the same state; the sweep repeats in full.
- SWEEP, one register per clock:
  - mem[cnt] ← (cnt==PRESET_IDX && PRESET_IDX!=0) ? PRESET_VAL : 0.
  - cnt increments each clock.
  - On the edge that writes cnt==NREGS-1, the block enters RUN and ready←1.
  - we and iss are ignored during SWEEP.
  - rd1 = rd2 = 0, busy1 = busy2 = 0, stall = 1.
- RUN, reads (combinational):
  - ra==0 → 0.
  - Otherwise, BYPASS && we && wa==ra → wd.
  - Otherwise → mem[ra].
- RUN, writes:
  - On a rising edge with we && wa!=0: mem[wa] ← wd.
  - Writes to x0 are dropped.
- RUN, scoreboard:
  - busy[0] is constantly 0.
  - On an edge with iss && iss_rd!=0: busy[iss_rd] ← 1.
  - On an edge with we && wa!=0: busy[wa] ← 0.
  - Same register set and cleared on the same edge → set wins (a new producer replaces the old one).
  - Clearing an already-idle register is legal and has no other effect.
- busyN = busy[raN], except that it reads 0 when BYPASS && we && wa==raN, because the value is forwarded that cycle.
- stall = !ready | (use1 & busy1) | (use2 & busy2).
- The block does not gate iss with stall. The issuing stage must not assert iss while stall is high; if it does, the scoreboard still updates.

## Timing
- Read latency is 0: rd1/rd2 are combinational from ra, mem and the bypass path.
- Writes are visible in mem on the first edge after we. With BYPASS=0, the written value first appears on rdN in the following cycle.
- Sweep length: ready rises on the NREGS-th rising edge after rst deasserts, which is 32 edges at the default NREGS.
- busy changes take effect on the edge after iss/we and are visible combinationally in the same cycle that follows.
- Reset values of outputs:
  - ready = 0, stall = 1.
  - busy1 = busy2 = 0.
  - rd1 = rd2 = 0.
- No output is registered except ready; all others are combinational from registered state plus the current inputs.

## Test plan
- Reset/sweep:
  - Pulse rst, then hold ra1=9, ra2=5.
  - Require ready=0 and stall=1 for 31 edges.
  - Require ready=1 after edge 32, then rd1=32'h20 and rd2=0.
  - Assert rst again at edge 10 of the sweep: ready must stay 0 for a full further 32 edges.
- Write/read and bypass:
  - In RUN, we=1, wa=3, wd=32'hDEADBEEF, ra1=3.
  - BYPASS=1: require rd1=DEADBEEF in the same cycle.
  - BYPASS=0: require rd1=0 that cycle and DEADBEEF next cycle.
- Zero register:
  - we=1, wa=0, wd=32'hFFFFFFFF, then iss=1, iss_rd=0.
  - Require rd1(ra1=0)=0, busy1=0 and stall=0 thereafter.
- Scoreboard hazard:
  - iss=1, iss_rd=7, then ra2=7 with use2=1 → busy2=1 and stall=1.
  - Same setup with use2=0 → stall=0.
  - Writeback we=1, wa=7, wd=5 → with BYPASS=1, busy2=0, stall=0 and rd2=5 in that cycle.
- Simultaneous set/clear:
  - On the same edge: iss=1, iss_rd=4 and we=1, wa=4.
  - Require busy[4]=1 afterwards; a later writeback to x4 clears it.
- Ignored during sweep:
  - Drive we=1, wa=2, wd=32'h55 and iss=1, iss_rd=2 during SWEEP.
  - After ready, require rd(ra=2)=0 and busy=0.
